uart_rx_deser: RTL and testbench

- Serial receive front-end for the CPLD UART on the 6809 board.
- Sits directly upstream of the UART register interface, which sits behind the 0xAxxx chip-select, and consumes the RXD pin.
- Synchronises and samples RXD (8N1, LSB first) and assembles bytes into a holding buffer.
- Raises data-valid, error and interrupt-request flags, and drives RTS_B flow control back to the remote end.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_fifo.sv | 128 ++++++++++++
 rtl/uart_rx_deser.sv | 143 ++++++++++++++
 tb/tb_uart_rx_deser.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive front-end.
// Holds the FSM state encoding, buffer geometry, the default bit divisor
// and the byte payload handed from the deserialiser to the receive buffer.
package uart_pkg;

    localparam int unsigned DATA_W          = 8;
    localparam int unsigned FIFO_DEPTH      = 4;
    localparam int unsigned PTR_W           = 2;
    localparam int unsigned FIFO_CNT_W      = 3;
    localparam int unsigned DEFAULT_DIVISOR = 104;
    localparam int unsigned DEFAULT_CNT_W   = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // One received frame: assembled byte plus "stop bit sampled low".
    typedef struct packed {
        logic              stop_err;
        logic [DATA_W-1:0] data;
    } rx_byte_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the deserialiser.
// Default build: a single holding register. With UART_RX_FIFO_EN defined:
// a 4-entry FIFO whose rts_b deasserts readiness at three stored bytes.
// Ports:
//   clk, reset     clock and asynchronous active-high reset
//   push           one-cycle strobe carrying push_byte from the deserialiser
//   push_byte      received byte plus stop-bit error
//   rd_ack         pops the head byte and clears the sticky error flags
//   dout           head byte, valid while rx_valid=1
//   rx_valid       buffer not empty
//   frame_err      sticky stop-bit error
//   overrun        sticky dropped-byte flag
//   rts_b          active-low ready-to-receive
//   irq            rx_valid | frame_err | overrun
module uart_rx_fifo
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  rx_byte_t          push_byte,
    input  logic              rd_ack,
    output logic [DATA_W-1:0] dout,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              overrun,
    output logic              rts_b,
    output logic              irq
);

    logic [DATA_W-1:0] dout_q, dout_n;
    logic              valid_q, valid_n;
    logic              ferr_q, ferr_n;
    logic              ovr_q, ovr_n;
    logic              rts_q, rts_n;
    logic              irq_q, irq_n;
    logic              accept_c;

`ifdef UART_RX_FIFO_EN

    logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_n;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_n;
    logic [FIFO_CNT_W-1:0] count_q, count_n;
    logic                  pop_c;

    // Pop is resolved before push, so a full FIFO still accepts on a pop cycle.
    always_comb begin
        pop_c    = rd_ack && (count_q != '0);
        accept_c = push && ((count_q != FIFO_CNT_W'(FIFO_DEPTH)) || pop_c);
        rd_ptr_n = rd_ptr_q + PTR_W'(pop_c);
        wr_ptr_n = wr_ptr_q + PTR_W'(accept_c);
        count_n  = count_q + FIFO_CNT_W'(accept_c) - FIFO_CNT_W'(pop_c);
        valid_n  = (count_n != '0);
        rts_n    = (count_n >= FIFO_CNT_W'(3));
        // Bypass when the byte being written becomes the new head.
        if (accept_c && (wr_ptr_q == rd_ptr_n)) begin
            dout_n = push_byte.data;
        end else begin
            dout_n = mem_q[rd_ptr_n];
        end
    end

    // Storage and pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept_c) begin
                mem_q[wr_ptr_q] <= push_byte.data;
            end
            rd_ptr_q <= rd_ptr_n;
            wr_ptr_q <= wr_ptr_n;
            count_q  <= count_n;
        end
    end

`else

    // Single holding register: an ack on the push cycle frees the slot first.
    always_comb begin
        accept_c = push && (!valid_q || rd_ack);
        valid_n  = accept_c || (valid_q && !rd_ack);
        dout_n   = accept_c ? push_byte.data : dout_q;
        rts_n    = valid_n;
    end

`endif

    // Sticky flags: a set on the ack cycle wins over the clear.
    always_comb begin
        ferr_n = (ferr_q && !rd_ack) || (push && push_byte.stop_err);
        ovr_n  = (ovr_q && !rd_ack) || (push && !accept_c);
        irq_n  = valid_n || ferr_n || ovr_n;
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            rts_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            dout_q  <= dout_n;
            valid_q <= valid_n;
            ferr_q  <= ferr_n;
            ovr_q   <= ovr_n;
            rts_q   <= rts_n;
            irq_q   <= irq_n;
        end
    end

    assign dout      = dout_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign rts_b     = rts_q;
    assign irq       = irq_q;

endmodule

// File: rtl/uart_rx_deser.sv
// Serial receive front-end for the board UART: synchronises RXD, samples
// 8N1 frames (LSB first) at mid-bit and hands bytes to uart_rx_fifo.
// Build option UART_RX_FIFO_EN selects the 4-entry FIFO buffer instead of
// the single holding register.
// Ports:
//   clk        E clock, all state on its rising edge
//   reset      asynchronous active-high reset
//   rxd        raw serial input, idles high
//   rd_ack     pop head byte, clear error flags
//   dout       head byte (valid while rx_valid=1)
//   rx_valid   buffer holds at least one byte
//   frame_err  sticky: stop bit sampled low
//   overrun    sticky: byte dropped on a full buffer
//   rts_b      active-low ready-to-receive
//   irq        rx_valid | frame_err | overrun
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int unsigned DIVISOR = DEFAULT_DIVISOR,
    parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rxd,
    input  logic              rd_ack,
    output logic [DATA_W-1:0] dout,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              overrun,
    output logic              rts_b,
    output logic              irq
);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(DIVISOR - 1);

    logic              sync1_q;
    logic              rxs_q;
    state_t            state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [DATA_W-1:0] shift_q, shift_n;
    logic [2:0]        bit_cnt_q, bit_cnt_n;
    logic              cnt_zero_c;
    logic              push_c;
    rx_byte_t          push_byte_c;

    // Two-flop synchroniser; idle level is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rxd;
            rxs_q   <= sync1_q;
        end
    end

    // FSM and bit-timing state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            shift_q   <= shift_n;
            bit_cnt_q <= bit_cnt_n;
        end
    end

    assign cnt_zero_c = (cnt_q == '0);

    // Next state: half-bit delay to the start-bit centre, then full bits.
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        shift_n     = shift_q;
        bit_cnt_n   = bit_cnt_q;
        push_c      = 1'b0;
        push_byte_c = '{stop_err: !rxs_q, data: shift_q};

        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    cnt_n   = HALF_LOAD;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (cnt_zero_c) begin
                    if (!rxs_q) begin
                        cnt_n     = FULL_LOAD;
                        bit_cnt_n = '0;
                        state_n   = S_DATA;
                    end else begin
                        // Start bit gone by its centre: treat as a glitch.
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_zero_c) begin
                    shift_n   = {rxs_q, shift_q[DATA_W-1:1]};
                    bit_cnt_n = bit_cnt_q + 3'd1;
                    cnt_n     = FULL_LOAD;
                    if (bit_cnt_q == 3'd7) begin
                        state_n = S_STOP;
                    end
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_zero_c) begin
                    push_c  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    uart_rx_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .push_byte (push_byte_c),
        .rd_ack    (rd_ack),
        .dout      (dout),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rts_b     (rts_b),
        .irq       (irq)
    );

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser at DIVISOR=8: table of frames, a byte-queue
// reference model, and hand-written glitch, overrun and reset sequences.
module tb_uart_rx_deser;
    import uart_pkg::*;

    localparam int unsigned DIV = 8;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       rd_ack = 1'b0;
    logic [7:0] dout;
    logic       rx_valid, frame_err, overrun, rts_b, irq;

    uart_rx_deser #(.DIVISOR(DIV), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rd_ack    (rd_ack),
        .dout      (dout),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rts_b     (rts_b),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   rise_cyc = -1;
    logic valid_prev = 1'b0;
    always @(negedge clk) begin
        if (rx_valid && !valid_prev) rise_cyc = cyc;
        valid_prev = rx_valid;
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];
    bit         exp_ovr  = 1'b0;
    bit         exp_ferr = 1'b0;
    int         last_fall = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_state(input string tag);
        bit exp_rts;
`ifdef UART_RX_FIFO_EN
        exp_rts = (exp_q.size() >= 3);
`else
        exp_rts = (exp_q.size() > 0);
`endif
        check({tag, "_valid"}, 32'(rx_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) check({tag, "_dout"}, 32'(dout), 32'(exp_q[0]));
        check({tag, "_ferr"}, 32'(frame_err), 32'(exp_ferr));
        check({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
        check({tag, "_rts"}, 32'(rts_b), 32'(exp_rts));
        check({tag, "_irq"}, 32'(irq), 32'((exp_q.size() > 0) || exp_ferr || exp_ovr));
    endtask

    // Drive nbits of a frame at DIV clk/bit; optionally ack on the push cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int nbits, input bit ack_push);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        @(negedge clk);
        last_fall = cyc;
        for (int i = 0; i < nbits; i++) begin
            rxd = bits[i];
            for (int j = 0; j < int'(DIV); j++) begin
                @(negedge clk);
                rd_ack = ack_push && (cyc == last_fall + 78);
            end
        end
        rxd    = 1'b1;
        rd_ack = 1'b0;
        if (nbits == 10) begin
            if (ack_push) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                exp_ovr  = 1'b0;
                exp_ferr = 1'b0;
            end
            if (!stop) exp_ferr = 1'b1;
            if (exp_q.size() < CAP) exp_q.push_back(b);
            else exp_ovr = 1'b1;
        end
    endtask

    task automatic read_one(input string tag);
        @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        check_state(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int lat;

        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_data: 8'hA5, exp_ferr: 1'b0};
        vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_data: 8'h3C, exp_ferr: 1'b1};
        vecs[2] = '{data: 8'h00, stop: 1'b1, exp_data: 8'h00, exp_ferr: 1'b0};
        vecs[3] = '{data: 8'hFF, stop: 1'b1, exp_data: 8'hFF, exp_ferr: 1'b0};
        vecs[4] = '{data: 8'h81, stop: 1'b0, exp_data: 8'h81, exp_ferr: 1'b1};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(dout), 32'h0);
        check_state("rst");
        check("rst_state", 32'(dut.state_q), 32'(S_IDLE));
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Table-driven frames, each read back
        for (int i = 0; i < 5; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            send_frame(vecs[i].data, vecs[i].stop, 10, 1'b0);
            lat = rise_cyc - last_fall;
            check({tag, "_latency"}, 32'((lat >= 78 && lat <= 80) ? 79 : lat), 32'd79);
            check_state(tag);
            check({tag, "_tbl_dout"}, 32'(dout), 32'(vecs[i].exp_data));
            check({tag, "_tbl_ferr"}, 32'(frame_err), 32'(vecs[i].exp_ferr));
            read_one({tag, "_rd"});
            repeat (12) @(negedge clk);
        end

        // Glitch shorter than half a bit
        @(negedge clk);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_state", 32'(dut.state_q), 32'(S_IDLE));
        check_state("glitch");

`ifdef UART_RX_FIFO_EN
        // Five frames without reads: fill, then overrun
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, 10, 1'b0);
            check_state($sformatf("fifo_w%0d", i));
        end
        for (int i = 1; i <= 4; i++) begin
            read_one($sformatf("fifo_r%0d", i));
        end
        repeat (12) @(negedge clk);
`else
        // Back-to-back without a read: second byte dropped
        send_frame(8'h11, 1'b1, 10, 1'b0);
        send_frame(8'h22, 1'b1, 10, 1'b0);
        check_state("b2b");
        read_one("b2b_rd");
        repeat (12) @(negedge clk);
        // Same, with rd_ack on the second push cycle
        send_frame(8'h11, 1'b1, 10, 1'b0);
        send_frame(8'h22, 1'b1, 10, 1'b1);
        check_state("b2b_ack");
        check("b2b_ack_dout", 32'(dout), 32'h22);
        read_one("b2b_ack_rd");
        repeat (12) @(negedge clk);
`endif

        // Reset in the middle of a frame's data bits
        send_frame(8'h5A, 1'b1, 10, 1'b0);
        check_state("pre_rst");
        send_frame(8'h77, 1'b0, 4, 1'b0);
        check("mid_state", 32'(dut.state_q), 32'(S_DATA));
        reset = 1'b1;
        #1;
        exp_q.delete();
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        check("mid_rst_dout", 32'(dout), 32'h0);
        check("mid_rst_state", 32'(dut.state_q), 32'(S_IDLE));
        check_state("mid_rst");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h42, 1'b1, 10, 1'b0);
        check_state("post_rst");
        check("post_rst_dout", 32'(dout), 32'h42);
        read_one("post_rst_rd");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
